// File: rtl/regfile_write_arbiter_pkg.sv
// Shared types and constants for the register-file write arbiter.
package regfile_write_arbiter_pkg;

    localparam int unsigned DEFAULT_DATA_W = 32;
    localparam int unsigned DEFAULT_ADDR_W = 5;
    localparam int unsigned REG_ZERO       = 0;
    // Wide enough for STARVE_LIMIT up to 7.
    localparam int unsigned STARVE_W       = 3;

    typedef enum logic {
        MEM_PRIO = 1'b0,
        ALU_PRIO = 1'b1
    } mode_e;

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Writeback request, register-file write and decode hazard signals.
interface regfile_write_arbiter_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
);
    logic              alu_wr_valid;
    logic              alu_wr_ready;
    logic [ADDR_W-1:0] alu_wr_reg;
    logic [DATA_W-1:0] alu_wr_data;
    logic              mem_wr_valid;
    logic              mem_wr_ready;
    logic [ADDR_W-1:0] mem_wr_reg;
    logic [DATA_W-1:0] mem_wr_data;
    logic              mem_wr_byte;
    logic              mem_wr_signed;
    logic              rf_reg_write;
    logic [ADDR_W-1:0] rf_write_reg;
    logic [DATA_W-1:0] rf_write_data;
    logic [ADDR_W-1:0] rd_reg1;
    logic [ADDR_W-1:0] rd_reg2;
    logic              rd_pending1;
    logic              rd_pending2;

    modport master (
        output alu_wr_valid, alu_wr_reg, alu_wr_data,
        output mem_wr_valid, mem_wr_reg, mem_wr_data, mem_wr_byte, mem_wr_signed,
        output rd_reg1, rd_reg2,
        input  alu_wr_ready, mem_wr_ready,
        input  rf_reg_write, rf_write_reg, rf_write_data,
        input  rd_pending1, rd_pending2
    );

    modport slave (
        input  alu_wr_valid, alu_wr_reg, alu_wr_data,
        input  mem_wr_valid, mem_wr_reg, mem_wr_data, mem_wr_byte, mem_wr_signed,
        input  rd_reg1, rd_reg2,
        output alu_wr_ready, mem_wr_ready,
        output rf_reg_write, rf_write_reg, rf_write_data,
        output rd_pending1, rd_pending2
    );

endinterface

// File: rtl/regfile_write_arbiter_load_extend.sv
// Byte-load sign/zero extension (lb/lbu); word loads pass through.
module regfile_write_arbiter_load_extend #(
    parameter int unsigned DATA_W = 32
) (
    input  logic [DATA_W-1:0] data,
    input  logic              is_byte,
    input  logic              is_signed,
    output logic [DATA_W-1:0] ext_data
);

    always_comb begin
        ext_data = data;
        if (is_byte) begin
            ext_data = {{(DATA_W-8){is_signed & data[7]}}, data[7:0]};
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between ALU and load writeback, with a
// one-cycle staged write and decode-side in-flight hazard flags.
module regfile_write_arbiter
    import regfile_write_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W       = DEFAULT_DATA_W,
    parameter int unsigned ADDR_W       = DEFAULT_ADDR_W,
    parameter int unsigned STARVE_LIMIT = 3
) (
    input logic                 clk,
    input logic                 reset,
    regfile_write_arbiter_if.slave bus
);

    localparam logic [ADDR_W-1:0]   ZeroReg   = ADDR_W'(REG_ZERO);
    localparam logic [STARVE_W-1:0] LimitM1   = STARVE_W'(STARVE_LIMIT - 1);
    localparam logic [STARVE_W-1:0] StarveMax = STARVE_W'(STARVE_LIMIT);

    mode_e               mode_q, mode_d;
    logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;
    logic                stage_we_q, stage_we_d;
    logic [ADDR_W-1:0]   stage_reg_q, stage_reg_d;
    logic [DATA_W-1:0]   stage_data_q, stage_data_d;
    logic                alu_grant, mem_grant;
    logic [DATA_W-1:0]   mem_data_ext;

    regfile_write_arbiter_load_extend #(
        .DATA_W (DATA_W)
    ) u_load_extend (
        .data      (bus.mem_wr_data),
        .is_byte   (bus.mem_wr_byte),
        .is_signed (bus.mem_wr_signed),
        .ext_data  (mem_data_ext)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q       <= MEM_PRIO;
            starve_cnt_q <= '0;
            stage_we_q   <= 1'b0;
            stage_reg_q  <= '0;
            stage_data_q <= '0;
        end else begin
            mode_q       <= mode_d;
            starve_cnt_q <= starve_cnt_d;
            stage_we_q   <= stage_we_d;
            stage_reg_q  <= stage_reg_d;
            stage_data_q <= stage_data_d;
        end
    end

    always_comb begin
        mode_d       = mode_q;
        starve_cnt_d = starve_cnt_q;
        if (alu_grant) begin
            starve_cnt_d = '0;
            mode_d       = MEM_PRIO;
        end else if (bus.alu_wr_valid) begin
            if (starve_cnt_q < StarveMax) begin
                starve_cnt_d = starve_cnt_q + STARVE_W'(1);
            end
            if (mode_q == MEM_PRIO && starve_cnt_q >= LimitM1) begin
                mode_d = ALU_PRIO;
            end
        end

        // Writes to $zero still take the slot but never reach the register file.
        stage_we_d   = 1'b0;
        stage_reg_d  = stage_reg_q;
        stage_data_d = stage_data_q;
        if (mem_grant) begin
            stage_we_d   = (bus.mem_wr_reg != ZeroReg);
            stage_reg_d  = bus.mem_wr_reg;
            stage_data_d = mem_data_ext;
        end else if (alu_grant) begin
            stage_we_d   = (bus.alu_wr_reg != ZeroReg);
            stage_reg_d  = bus.alu_wr_reg;
            stage_data_d = bus.alu_wr_data;
        end
    end

    always_comb begin
        alu_grant = 1'b0;
        mem_grant = 1'b0;
        if (mode_q == MEM_PRIO) begin
            mem_grant = bus.mem_wr_valid;
            alu_grant = bus.alu_wr_valid && !bus.mem_wr_valid;
        end else begin
            alu_grant = bus.alu_wr_valid;
            mem_grant = bus.mem_wr_valid && !bus.alu_wr_valid;
        end
    end

    function automatic logic reg_pending(input logic [ADDR_W-1:0] rd,
                                         input logic              s_we,
                                         input logic [ADDR_W-1:0] s_reg,
                                         input logic              a_vld,
                                         input logic [ADDR_W-1:0] a_reg,
                                         input logic              m_vld,
                                         input logic [ADDR_W-1:0] m_reg);
        return (rd != ZeroReg) &&
               ((s_we && s_reg == rd) || (a_vld && a_reg == rd) || (m_vld && m_reg == rd));
    endfunction

    assign bus.alu_wr_ready  = alu_grant;
    assign bus.mem_wr_ready  = mem_grant;
    // Masked during reset so a write staged just before reset never lands.
    assign bus.rf_reg_write  = stage_we_q && !reset;
    assign bus.rf_write_reg  = stage_reg_q;
    assign bus.rf_write_data = stage_data_q;

    assign bus.rd_pending1 = reg_pending(bus.rd_reg1, stage_we_q, stage_reg_q,
                                         bus.alu_wr_valid, bus.alu_wr_reg,
                                         bus.mem_wr_valid, bus.mem_wr_reg);
    assign bus.rd_pending2 = reg_pending(bus.rd_reg2, stage_we_q, stage_reg_q,
                                         bus.alu_wr_valid, bus.alu_wr_reg,
                                         bus.mem_wr_valid, bus.mem_wr_reg);

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter with hand-computed expectations.
module tb_regfile_write_arbiter;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fails;

    regfile_write_arbiter_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    regfile_write_arbiter #(
        .DATA_W       (32),
        .ADDR_W       (5),
        .STARVE_LIMIT (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected grant sequences: 1 = mem, 0 = alu.
    logic [5:0] starve_pat;
    logic [3:0] rst_pat;

    initial begin
        n_checks = 0;
        n_fails  = 0;
        reset = 1'b1;
        bus.alu_wr_valid = 1'b0; bus.alu_wr_reg = '0; bus.alu_wr_data = '0;
        bus.mem_wr_valid = 1'b0; bus.mem_wr_reg = '0; bus.mem_wr_data = '0;
        bus.mem_wr_byte = 1'b0;  bus.mem_wr_signed = 1'b0;
        bus.rd_reg1 = '0; bus.rd_reg2 = '0;
        tick();
        tick();
        check("reset_we", 32'(bus.rf_reg_write), 32'd0);
        check("reset_reg", 32'(bus.rf_write_reg), 32'd0);
        check("reset_data", bus.rf_write_data, 32'd0);
        reset = 1'b0;
        tick();
        check("idle_we", 32'(bus.rf_reg_write), 32'd0);

        // ALU only
        bus.alu_wr_valid = 1'b1; bus.alu_wr_reg = 5'd8; bus.alu_wr_data = 32'h0000_1234;
        #1;
        check("alu_only_ready", 32'(bus.alu_wr_ready), 32'd1);
        check("alu_only_mem_ready", 32'(bus.mem_wr_ready), 32'd0);
        tick();
        bus.alu_wr_valid = 1'b0;
        check("alu_only_we", 32'(bus.rf_reg_write), 32'd1);
        check("alu_only_reg", 32'(bus.rf_write_reg), 32'd8);
        check("alu_only_data", bus.rf_write_data, 32'h0000_1234);
        tick();
        check("alu_only_we_after", 32'(bus.rf_reg_write), 32'd0);

        // Collision on register 9
        bus.mem_wr_valid = 1'b1; bus.mem_wr_reg = 5'd9; bus.mem_wr_data = 32'hAAAA_0000;
        bus.alu_wr_valid = 1'b1; bus.alu_wr_reg = 5'd9; bus.alu_wr_data = 32'h0000_5555;
        #1;
        check("coll_mem_first", 32'(bus.mem_wr_ready), 32'd1);
        check("coll_alu_wait", 32'(bus.alu_wr_ready), 32'd0);
        tick();
        bus.mem_wr_valid = 1'b0;
        #1;
        check("coll_alu_second", 32'(bus.alu_wr_ready), 32'd1);
        check("coll_wr1_we", 32'(bus.rf_reg_write), 32'd1);
        check("coll_wr1_data", bus.rf_write_data, 32'hAAAA_0000);
        tick();
        bus.alu_wr_valid = 1'b0;
        check("coll_wr2_we", 32'(bus.rf_reg_write), 32'd1);
        check("coll_wr2_data", bus.rf_write_data, 32'h0000_5555);
        tick();

        // Starvation: mem,mem,mem,alu then back to load priority
        starve_pat = 6'b11_0111;
        bus.mem_wr_valid = 1'b1; bus.mem_wr_reg = 5'd3; bus.mem_wr_data = 32'h11;
        bus.alu_wr_valid = 1'b1; bus.alu_wr_reg = 5'd4; bus.alu_wr_data = 32'h22;
        for (int c = 0; c < 6; c++) begin
            #1;
            check($sformatf("starve_mem_c%0d", c), 32'(bus.mem_wr_ready), 32'(starve_pat[c]));
            check($sformatf("starve_alu_c%0d", c), 32'(bus.alu_wr_ready), 32'(!starve_pat[c]));
            tick();
        end
        check("starve_last_data", bus.rf_write_data, 32'h11);

        // Counter now at 2; a mem-only grant leaves it there, then reset clears it
        bus.alu_wr_valid = 1'b0;
        bus.mem_wr_reg = 5'd7; bus.mem_wr_data = 32'h77;
        tick();
        bus.mem_wr_valid = 1'b0;
        reset = 1'b1;
        #1;
        check("rst_we_n1", 32'(bus.rf_reg_write), 32'd0);
        tick();
        reset = 1'b0;
        check("rst_we_n2", 32'(bus.rf_reg_write), 32'd0);
        rst_pat = 4'b0111;
        bus.mem_wr_valid = 1'b1; bus.mem_wr_reg = 5'd3; bus.mem_wr_data = 32'h11;
        bus.alu_wr_valid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            check($sformatf("rst_mem_c%0d", c), 32'(bus.mem_wr_ready), 32'(rst_pat[c]));
            tick();
        end
        bus.mem_wr_valid = 1'b0; bus.alu_wr_valid = 1'b0;
        tick();

        // Byte loads
        bus.mem_wr_valid = 1'b1; bus.mem_wr_reg = 5'd5; bus.mem_wr_data = 32'h1234_56F0;
        bus.mem_wr_byte = 1'b1; bus.mem_wr_signed = 1'b1;
        tick();
        check("lb_data", bus.rf_write_data, 32'hFFFF_FFF0);
        bus.mem_wr_signed = 1'b0;
        tick();
        check("lbu_data", bus.rf_write_data, 32'h0000_00F0);
        bus.mem_wr_byte = 1'b0;
        tick();
        check("lw_data", bus.rf_write_data, 32'h1234_56F0);
        check("lw_we", 32'(bus.rf_reg_write), 32'd1);
        bus.mem_wr_valid = 1'b0;
        tick();

        // $zero write and pending flags
        bus.alu_wr_valid = 1'b1; bus.alu_wr_reg = 5'd0; bus.alu_wr_data = 32'hDEAD;
        #1;
        check("zero_ready", 32'(bus.alu_wr_ready), 32'd1);
        tick();
        bus.alu_wr_valid = 1'b0;
        check("zero_we", 32'(bus.rf_reg_write), 32'd0);
        bus.mem_wr_valid = 1'b1; bus.mem_wr_reg = 5'd12; bus.mem_wr_data = 32'h5;
        bus.rd_reg1 = 5'd12; bus.rd_reg2 = 5'd0;
        #1;
        check("pend1_req", 32'(bus.rd_pending1), 32'd1);
        check("pend2_zero", 32'(bus.rd_pending2), 32'd0);
        tick();
        bus.mem_wr_valid = 1'b0;
        #1;
        check("pend1_staged", 32'(bus.rd_pending1), 32'd1);
        tick();
        check("pend1_clear", 32'(bus.rd_pending1), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
Shares the register file's single write port between two writeback requesters: ALU results and memory loads. Arbitrates with load priority plus an anti-starvation counter, and sign- or zero-extends byte loads (lb/lbu). Registers the granted write for one cycle before it reaches the register file. Reports to decode whether a source register has an in-flight write.

Parameters:
DATA_W, 32, register data width
ADDR_W, 5, register index width
STARVE_LIMIT, 3, consecutive ALU losses before the ALU gets priority (1..7)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
alu_wr_valid  input  1  ALU write request
alu_wr_ready  output  1  ALU request granted this cycle
alu_wr_reg  input  ADDR_W  ALU destination register
alu_wr_data  input  DATA_W  ALU result
mem_wr_valid  input  1  load write request
mem_wr_ready  output  1  load request granted this cycle
mem_wr_reg  input  ADDR_W  load destination register
mem_wr_data  input  DATA_W  raw load data
mem_wr_byte  input  1  byte load: use bits [7:0] only
mem_wr_signed  input  1  with mem_wr_byte: 1 = sign-extend (lb), 0 = zero-extend (lbu)
rf_reg_write  output  1  register file write enable
rf_write_reg  output  ADDR_W  register file write index
rf_write_data  output  DATA_W  register file write data
rd_reg1, rd_reg2  input  ADDR_W  decode source registers
rd_pending1, rd_pending2  output  1  source register has an in-flight write

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high. Clock port is clk, reset port is reset.
- Reset values:
  - rf_reg_write=0, rf_write_reg=0, rf_write_data=0.
  - Mode=MEM_PRIO, starve_cnt=0.
  - Reset asserted mid-operation discards any staged write; no rf write occurs in the cycle after reset.
- Handshake:
  - A request transfers in a cycle where valid && ready.
  - ready is combinational from the valid inputs and mode; it never depends on the data inputs.
  - At most one of alu_wr_ready and mem_wr_ready is high per cycle.
  - A requester must hold valid, reg and data stable until ready.
- FSM modes:
  - MEM_PRIO: mem wins if mem_wr_valid; otherwise alu wins if alu_wr_valid.
  - ALU_PRIO: alu wins if alu_wr_valid; otherwise mem.
- Starvation counter:
  - starve_cnt increments when alu_wr_valid && !alu_wr_ready, and clears on an ALU grant.
  - MEM_PRIO -> ALU_PRIO when starve_cnt reaches STARVE_LIMIT-1 and the ALU loses again in this cycle.
  - ALU_PRIO -> MEM_PRIO after any ALU grant.
  - The counter saturates and never wraps.
- Output stage:
  - A grant in cycle N drives rf_reg_write=1, rf_write_reg and rf_write_data in cycle N+1 only (latency 1).
  - With no grant in cycle N, rf_reg_write=0 in cycle N+1.
  - The stage is rewritten every cycle, and the register file accepts every cycle, so there is no backpressure.
- Register $zero:
  - A request to register 0 is still granted and consumes a slot.
  - The staged write has rf_reg_write forced to 0.
- Data path:
  - ALU data passes through unchanged.
  - Load data:
    - mem_wr_byte=0: full word.
    - mem_wr_byte=1, mem_wr_signed=1: {24{d[7]}, d[7:0]}.
    - mem_wr_byte=1, mem_wr_signed=0: {24'b0, d[7:0]}.
  - Extension happens before staging.
- Pending flags (combinational): rd_pendingK is high when any of the following holds:
  - the staged write is valid, non-zero and rf_write_reg==rd_regK; or
  - alu_wr_valid and alu_wr_reg==rd_regK, with rd_regK!=0; or
  - mem_wr_valid and mem_wr_reg==rd_regK, with rd_regK!=0.
  - rd_regK==0 always reports 0.
- Simultaneous requests to the same register: the load wins first under MEM_PRIO. The ALU write follows, so the ALU value is the final value, which is correct program order because the ALU instruction is younger.

Decomposition:
- Shared package: DATA_W/ADDR_W defaults, REG_ZERO constant, mode enum {MEM_PRIO, ALU_PRIO}.
- One natural sub-module, load_extend: combinational byte sign/zero extension, reusable by the memory stage.

Test Plan:
- ALU only: alu valid, reg 8, data 0x0000_1234 -> alu_wr_ready=1 in cycle 0; cycle 1 has rf_reg_write=1, reg 8, data 0x0000_1234; cycle 2 has rf_reg_write=0.
- Collision:
  - Stimulus: both valid from cycle 0; mem holds reg 9 / 0xAAAA_0000 until granted; alu holds reg 9 / 0x5555 until granted.
  - Response: mem is granted first; the alu grant follows; the rf writes in order are 0xAAAA_0000 then 0x5555.
- Starvation (STARVE_LIMIT=3):
  - Stimulus: continuous mem and alu requests.
  - Response: grants mem, mem, mem; then alu in cycle 3; then the mode returns to MEM_PRIO.
- Byte loads with data 0x1234_56F0:
  - lb -> 0xFFFF_FFF0.
  - lbu -> 0x0000_00F0.
  - Word load -> 0x1234_56F0.
- $zero and pending:
  - alu write to reg 0 -> granted, with rf_reg_write=0 the next cycle.
  - rd_reg1=12 while mem valid to reg 12 -> rd_pending1=1.
  - rd_reg2=0 -> rd_pending2=0.
- Reset mid-operation: grant in cycle N, reset in cycle N+1 -> rf_reg_write=0 in cycle N+1 and N+2; mode=MEM_PRIO and starve_cnt=0 afterwards.
